pwm_decoder: RTL
================

# pwm_decoder

- Receives a hobby-servo PWM signal and measures its high time and frame period in 24 MHz `int_osc` cycles.
- Validates each complete frame and converts the pulse width to a 0–180° angle.
- Reports the result with a one-cycle strobe.
- Sits on the input side of the FPGA, opposite the servo PWM generator. Its output is used for closed-loop checking and for driving the angle display.

## Interface
Parameters:
- `PULSE_MIN`, 24000: pulse width (cycles) mapped to 0° (1.0 ms)
- `PULSE_MAX`, 48000: pulse width mapped to 180° (2.0 ms)
- `ACC_MIN`, 19200: shortest accepted pulse (0.8 ms)
- `ACC_MAX`, 52800: longest accepted pulse (2.2 ms)
- `PERIOD_MIN`, 432000: shortest accepted frame (18 ms)
- `PERIOD_MAX`, 528000: longest accepted frame and timeout threshold (22 ms)

Ports:
- `clk`, in, 1: `int_osc`, 24 MHz
- `reset`, in, 1: reset, synchronous, active-low
- `pwm_in`, in, 1: asynchronous PWM input
- `pulse_cycles`, out, 20: high time of the last accepted frame
- `angle`, out, 8: angle of the last accepted frame, 0..180
- `valid`, out, 1: one-cycle strobe when `pulse_cycles`/`angle` update
- `err`, out, 1: one-cycle strobe when a complete frame is rejected
- `lost`, out, 1: level; no valid signal present

## Operation
- `pwm_in` passes through a 2-flop synchronizer, then an edge detector (`rise`/`fall`, one cycle each).
- Counters are 20 bits and saturate at all-ones:
  - `hi_cnt` counts cycles with the synchronized input high.
  - `per_cnt` counts cycles since the last rise.
  - On `rise`, both counters load 1.
- FSM states:
  - IDLE:
    - `rise` → HIGH, with no report, because no full frame exists yet.
    - `fall` is ignored.
  - HIGH:
    - `fall` → LOW, latching `hi_cnt` into `width_q`.
  - LOW:
    - `rise` → HIGH and frame evaluation.
- Frame evaluation on `rise` in LOW:
  - Accept when `per_cnt` is in [PERIOD_MIN, PERIOD_MAX] and `width_q` is in [ACC_MIN, ACC_MAX].
  - Otherwise pulse `err`; outputs and `lost` hold.
- Conversion of an accepted frame:
  - `w` = `width_q` clamped to [PULSE_MIN, PULSE_MAX].
  - Numerator = (w − PULSE_MIN) × 180, computed by shift-add (x≪7 + x≪5 + x≪4 + x≪2). It is 23 bits wide.
  - The sequential divider computes numerator ÷ (PULSE_MAX − PULSE_MIN), floor, 8-bit quotient.
- On divider done:
  - `angle` ← quotient.
  - `pulse_cycles` ← unclamped `width_q`.
  - `valid` ← 1 for that cycle.
  - `lost` ← 0.
- Timeout: in HIGH or LOW, when `per_cnt` reaches PERIOD_MAX+1 without a rise:
  - `lost` ← 1 and the FSM goes to IDLE. This also covers a stuck-high or stuck-low input.
  - No `err` strobe.
  - The divider, if running, completes normally.
- The divider runs in parallel with measurement of the next frame. Its 9-cycle busy window is far shorter than ACC_MIN, so an overlap cannot occur.

## Timing
- Reset values: `pulse_cycles`=0, `angle`=0, `valid`=0, `err`=0, `lost`=1; FSM=IDLE; counters=0; synchronizer flops=0; divider idle.
- Reset asserted mid-frame or mid-division aborts everything on the next clock. The first frame after release produces no report. The first report comes at the second rise.
- Pin-to-`rise`/`fall` latency is 3 cycles, identical for both edges, so measured widths are exact to ±1 cycle of input jitter.
- Latency of an accepted frame:
  - Cycle R is the cycle with `rise` high.
  - R+1: numerator registered, divider started.
  - R+2 through R+9: one quotient bit per cycle, 8 iterations.
  - R+10: `valid` high and outputs updated.
- `err` is high in cycle R+1 for a rejected frame.
- `valid` and `err` never assert in the same cycle. `valid` is a single cycle per accepted frame.
- Boundaries:
  - Width exactly ACC_MIN/ACC_MAX and period exactly PERIOD_MIN/PERIOD_MAX are accepted.
  - `per_cnt` = PERIOD_MAX at a rise is accepted; PERIOD_MAX+1 triggers timeout first.

## Structure
- Package `pwm_rx_pkg`:
  - Cycle constants (defaults above, `CLK_HZ`=24_000_000).
  - `state_t` enum {IDLE, HIGH, LOW}.
  - Counter width localparam (20).
- Sub-module `seq_div8`:
  - Restoring divider: 23-bit numerator, 15-bit denominator, 8-bit quotient.
  - Handshake: `start` pulse in, `done` pulse out after 8 iterations.
  - Denominator pre-shifted by 7.

## Test plan
- 1.5 ms high (36000 cycles), 20 ms period (480000), three frames → first two rises yield one `valid`, with `angle`=90 and `pulse_cycles`=36000; `valid` asserts at R+10 after each subsequent rise.
- 1.0 ms and 2.0 ms pulses → `angle`=0 and `angle`=180. A 2.1 ms pulse (50400) → `angle`=180 and `pulse_cycles`=50400.
- 0.5 ms pulse (12000) and, separately, a 10 ms period (240000) → `err` strobe at R+1, no `valid`, outputs unchanged.
- Input held low 600000 cycles after a valid frame → `lost`=1 at cycle 528001 after the last rise. The next two good frames restore `valid` and clear `lost`.
- `reset`=0 for 1 cycle mid-pulse → all outputs at reset values, `lost`=1. The first subsequent rise gives no report.
- Glitch: 1-cycle high pulse inside the LOW phase → the period check rejects it with `err`. The next good frame reports normally.

Source files
------------

// File: rtl/pwm_rx_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the servo PWM receiver.
package pwm_rx_pkg;

   localparam int unsigned CLK_HZ = 24_000_000;

   // Default timing in int_osc cycles
   localparam int unsigned DEF_PULSE_MIN  = 24000;   // 1.0 ms -> 0 deg
   localparam int unsigned DEF_PULSE_MAX  = 48000;   // 2.0 ms -> 180 deg
   localparam int unsigned DEF_ACC_MIN    = 19200;   // 0.8 ms
   localparam int unsigned DEF_ACC_MAX    = 52800;   // 2.2 ms
   localparam int unsigned DEF_PERIOD_MIN = 432000;  // 18 ms
   localparam int unsigned DEF_PERIOD_MAX = 528000;  // 22 ms

   localparam int unsigned CNT_W = 20;
   localparam int unsigned NUM_W = 23;
   localparam int unsigned DEN_W = 15;
   localparam int unsigned Q_W   = 8;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   // x * 180 without a multiplier: 128 + 32 + 16 + 4
   function automatic logic [NUM_W-1:0] mul180(input logic [NUM_W-1:0] x);
      return (x << 7) + (x << 5) + (x << 4) + (x << 2);
   endfunction

endpackage

// File: rtl/seq_div8.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
// The first bit is resolved in the start cycle; done pulses after the 8th bit.
module seq_div8
   import pwm_rx_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             done,
   output logic [Q_W-1:0]   quotient
);

   logic [NUM_W-1:0]   rem_q, src_rem, rem_nxt;
   logic [DEN_W+6:0]   dsh_q, src_dsh;
   logic [Q_W-1:0]     quo_q;
   logic [2:0]         cnt_q;
   logic               busy_q, done_q, ge;

   // One trial subtraction; on start it works on the fresh operands directly
   always_comb begin
      src_rem = start ? num : rem_q;
      src_dsh = start ? {den, 7'b0} : dsh_q;
      ge      = src_rem >= {1'b0, src_dsh};
      rem_nxt = ge ? (src_rem - {1'b0, src_dsh}) : src_rem;
   end

   // Iteration state and the done pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q  <= '0;
         dsh_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem_q  <= rem_nxt;
            dsh_q  <= src_dsh >> 1;
            quo_q  <= {{(Q_W-1){1'b0}}, ge};
            cnt_q  <= 3'd1;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_nxt;
            dsh_q <= dsh_q >> 1;
            quo_q <= {quo_q[Q_W-2:0], ge};
            if (cnt_q == 3'd7) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 3'd1;
            end
         end
      end
   end

   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/pwm_decoder.sv
// Hobby-servo PWM receiver: measures high time and frame period, validates each
// frame and converts the pulse width into a 0..180 degree angle.
module pwm_decoder
   import pwm_rx_pkg::*;
#(
   parameter int unsigned PULSE_MIN  = DEF_PULSE_MIN,
   parameter int unsigned PULSE_MAX  = DEF_PULSE_MAX,
   parameter int unsigned ACC_MIN    = DEF_ACC_MIN,
   parameter int unsigned ACC_MAX    = DEF_ACC_MAX,
   parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
   parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] pulse_cycles,
   output logic [Q_W-1:0]   angle,
   output logic             valid,
   output logic             err,
   output logic             lost
);

   localparam logic [CNT_W-1:0] PULSE_MIN_C  = CNT_W'(PULSE_MIN);
   localparam logic [CNT_W-1:0] PULSE_MAX_C  = CNT_W'(PULSE_MAX);
   localparam logic [CNT_W-1:0] ACC_MIN_C    = CNT_W'(ACC_MIN);
   localparam logic [CNT_W-1:0] ACC_MAX_C    = CNT_W'(ACC_MAX);
   localparam logic [CNT_W-1:0] PERIOD_MIN_C = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] PERIOD_MAX_C = CNT_W'(PERIOD_MAX);
   localparam logic [DEN_W-1:0] DEN_C        = DEN_W'(PULSE_MAX - PULSE_MIN);

   logic             sync1_q, sync2_q, sync3_q, rise, fall;
   logic [CNT_W-1:0] hi_cnt_q, per_cnt_q, width_q, rep_w_q;
   logic [CNT_W-1:0] w_cl;
   logic [NUM_W-1:0] num_q, num_d;
   logic             start_q, err_q, valid_q, lost_q;
   logic [CNT_W-1:0] pulse_q;
   logic [Q_W-1:0]   angle_q, quotient;
   logic             div_done;
   state_t           state_q, state_d;
   logic             accept, reject, timeout, latch_w, in_range;

   // Two-flop synchronizer plus a third flop for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rise = sync2_q & ~sync3_q;
   assign fall = ~sync2_q & sync3_q;

   // Saturating high-time and period counters; a rise counts as the first cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_cnt_q  <= '0;
         per_cnt_q <= '0;
      end else begin
         if (rise) begin
            hi_cnt_q <= CNT_W'(1);
         end else if (sync2_q && hi_cnt_q != '1) begin
            hi_cnt_q <= hi_cnt_q + CNT_W'(1);
         end
         if (rise) begin
            per_cnt_q <= CNT_W'(1);
         end else if (per_cnt_q != '1) begin
            per_cnt_q <= per_cnt_q + CNT_W'(1);
         end
      end
   end

   assign in_range = (per_cnt_q >= PERIOD_MIN_C) && (per_cnt_q <= PERIOD_MAX_C) &&
                     (width_q >= ACC_MIN_C) && (width_q <= ACC_MAX_C);

   // Next-state: timeout fires the cycle before per_cnt would pass PERIOD_MAX
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      timeout = 1'b0;
      latch_w = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) state_d = HIGH;
         end
         HIGH: begin
            if (per_cnt_q >= PERIOD_MAX_C) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               latch_w = 1'b1;
               state_d = LOW;
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
               accept  = in_range;
               reject  = ~in_range;
            end else if (per_cnt_q >= PERIOD_MAX_C) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Clamp the measured width into the mapped range and scale by 180
   always_comb begin
      w_cl = width_q;
      if (width_q < PULSE_MIN_C) w_cl = PULSE_MIN_C;
      if (width_q > PULSE_MAX_C) w_cl = PULSE_MAX_C;
      num_d = mul180(NUM_W'(w_cl - PULSE_MIN_C));
   end

   // Width capture, numerator register and divider kick-off
   always_ff @(posedge clk) begin
      if (!reset) begin
         width_q <= '0;
         rep_w_q <= '0;
         num_q   <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (latch_w) width_q <= hi_cnt_q;
         if (accept) begin
            num_q   <= num_d;
            rep_w_q <= width_q;
         end
         start_q <= accept;
         err_q   <= reject;
      end
   end

   seq_div8 u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (start_q),
      .num      (num_q),
      .den      (DEN_C),
      .done     (div_done),
      .quotient (quotient)
   );

   // Result registers, strobe and signal-lost level
   always_ff @(posedge clk) begin
      if (!reset) begin
         pulse_q <= '0;
         angle_q <= '0;
         valid_q <= 1'b0;
         lost_q  <= 1'b1;
      end else begin
         valid_q <= div_done;
         if (div_done) begin
            angle_q <= quotient;
            pulse_q <= rep_w_q;
         end
         if (timeout)       lost_q <= 1'b1;
         else if (div_done) lost_q <= 1'b0;
      end
   end

   assign pulse_cycles = pulse_q;
   assign angle        = angle_q;
   assign valid        = valid_q;
   assign err          = err_q;
   assign lost         = lost_q;

endmodule
